// File: rtl/hall_sensor_emulator.sv
// Three-phase Hall sensor pattern generator for BLDC commutation bring-up.
// Steps through the six-state Hall sequence at a programmable rate, finite or continuous.
module hall_sensor_emulator #(
   parameter int unsigned CNT_WIDTH  = 16,
   parameter int unsigned STEP_WIDTH = 16,
   parameter int unsigned INIT_PHASE = 0
) (
   input  logic                  clk_i,
   input  logic                  rst_ni,
   input  logic                  start_i,
   input  logic                  stop_i,
   input  logic                  dir_i,
   input  logic [CNT_WIDTH-1:0]  period_i,
   input  logic [STEP_WIDTH-1:0] steps_i,
   input  logic                  fault_inj_i,
   output logic                  ha_o,
   output logic                  hb_o,
   output logic                  hc_o,
   output logic [2:0]            phase_o,
   output logic                  busy_o,
   output logic                  step_pulse_o,
   output logic                  done_o
);

   localparam logic [0:0] StIdle = 1'b0;
   localparam logic [0:0] StRun  = 1'b1;

   localparam logic [CNT_WIDTH-1:0]  CntOne    = CNT_WIDTH'(1);
   localparam logic [STEP_WIDTH-1:0] StepOne   = STEP_WIDTH'(1);
   localparam logic [2:0]            InitPhase = 3'(INIT_PHASE);

   function automatic logic [2:0] hall_code(input logic [2:0] p);
      logic [2:0] code;
      case (p)
         3'd0:    code = 3'b100;
         3'd1:    code = 3'b110;
         3'd2:    code = 3'b010;
         3'd3:    code = 3'b011;
         3'd4:    code = 3'b001;
         3'd5:    code = 3'b101;
         default: code = 3'b100;
      endcase
      return code;
   endfunction

   logic [0:0]            state_q, state_d;
   logic [CNT_WIDTH-1:0]  cnt_q, cnt_d;
   logic [CNT_WIDTH-1:0]  period_q, period_d;
   logic                  dir_q, dir_d;
   logic [STEP_WIDTH-1:0] remain_q, remain_d;
   logic [2:0]            phase_q, phase_d;
   logic [2:0]            hall_q, hall_d;
   logic                  step_pulse_q, step_pulse_d;
   logic                  done_q, done_d;
   logic [2:0]            phase_next;

   always_comb begin
      if (dir_q) begin
         phase_next = (phase_q == 3'd5) ? 3'd0 : phase_q + 3'd1;
      end else begin
         phase_next = (phase_q == 3'd0) ? 3'd5 : phase_q - 3'd1;
      end
   end

   always_comb begin
      state_d      = state_q;
      cnt_d        = cnt_q;
      period_d     = period_q;
      dir_d        = dir_q;
      remain_d     = remain_q;
      phase_d      = phase_q;
      step_pulse_d = 1'b0;
      done_d       = 1'b0;
      case (state_q)
         StIdle: begin
            if (start_i && !stop_i) begin
               state_d  = StRun;
               period_d = (period_i == '0) ? CntOne : period_i;
               dir_d    = dir_i;
               remain_d = steps_i;
               cnt_d    = '0;
            end
         end
         StRun: begin
            // stop wins over a step falling due on the same edge
            if (stop_i) begin
               state_d = StIdle;
            end else if (cnt_q == period_q - CntOne) begin
               cnt_d        = '0;
               phase_d      = phase_next;
               step_pulse_d = 1'b1;
               // remain_q == 0 means continuous mode
               if (remain_q != '0) begin
                  remain_d = remain_q - StepOne;
                  if (remain_q == StepOne) begin
                     done_d  = 1'b1;
                     state_d = StIdle;
                  end
               end
            end else begin
               cnt_d = cnt_q + CntOne;
            end
         end
         default: state_d = StIdle;
      endcase
      hall_d = fault_inj_i ? 3'b000 : hall_code(phase_d);
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state_q      <= StIdle;
         cnt_q        <= '0;
         period_q     <= CntOne;
         dir_q        <= 1'b1;
         remain_q     <= '0;
         phase_q      <= InitPhase;
         hall_q       <= hall_code(InitPhase);
         step_pulse_q <= 1'b0;
         done_q       <= 1'b0;
      end else begin
         state_q      <= state_d;
         cnt_q        <= cnt_d;
         period_q     <= period_d;
         dir_q        <= dir_d;
         remain_q     <= remain_d;
         phase_q      <= phase_d;
         hall_q       <= hall_d;
         step_pulse_q <= step_pulse_d;
         done_q       <= done_d;
      end
   end

   assign {ha_o, hb_o, hc_o} = hall_q;
   assign phase_o            = phase_q;
   assign busy_o             = (state_q == StRun);
   assign step_pulse_o       = step_pulse_q;
   assign done_o             = done_q;

endmodule

// File: tb/tb_hall_sensor_emulator.sv
// Self-checking bench for hall_sensor_emulator: scenario table, directed corner cases,
// and randomized stimulus against a cycle-level behavioural model.
module tb_hall_sensor_emulator;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        start, stop, dir, fault;
   logic [15:0] period, steps;
   logic        ha, hb, hc, busy, sp, done;
   logic [2:0]  phase;

   always #5 clk = ~clk;

   hall_sensor_emulator #(
      .CNT_WIDTH (16),
      .STEP_WIDTH(16),
      .INIT_PHASE(0)
   ) dut (
      .clk_i       (clk),
      .rst_ni      (rst_n),
      .start_i     (start),
      .stop_i      (stop),
      .dir_i       (dir),
      .period_i    (period),
      .steps_i     (steps),
      .fault_inj_i (fault),
      .ha_o        (ha),
      .hb_o        (hb),
      .hc_o        (hc),
      .phase_o     (phase),
      .busy_o      (busy),
      .step_pulse_o(sp),
      .done_o      (done)
   );

   int checks = 0;
   int errors = 0;

   logic [2:0] hall_tab [6] = '{3'b100, 3'b110, 3'b010, 3'b011, 3'b001, 3'b101};

   // Behavioural model: counts cycles since the last Hall change
   bit         m_run, m_sp, m_done, m_dir, m_cont;
   int         m_phase, m_per, m_left, m_since;
   logic [2:0] m_hall;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic model_reset();
      m_run = 0; m_sp = 0; m_done = 0; m_dir = 1; m_cont = 0;
      m_phase = 0; m_per = 1; m_left = 0; m_since = 0;
      m_hall = hall_tab[0];
   endtask

   task automatic model_step();
      m_sp = 0;
      m_done = 0;
      if (!m_run) begin
         if (start && !stop) begin
            m_run   = 1;
            m_per   = (period == 0) ? 1 : int'(period);
            m_dir   = dir;
            m_left  = int'(steps);
            m_cont  = (steps == 0);
            m_since = 0;
         end
      end else if (stop) begin
         m_run = 0;
      end else begin
         m_since++;
         if (m_since == m_per) begin
            m_since = 0;
            m_phase = (m_phase + (m_dir ? 1 : 5)) % 6;
            m_sp    = 1;
            if (!m_cont) begin
               m_left--;
               if (m_left == 0) begin
                  m_done = 1;
                  m_run  = 0;
               end
            end
         end
      end
      m_hall = fault ? 3'b000 : hall_tab[m_phase];
   endtask

   task automatic cmp_model();
      check("model_hall", {29'd0, ha, hb, hc}, {29'd0, m_hall});
      check("model_phase", {29'd0, phase}, m_phase);
      check("model_busy", {31'd0, busy}, {31'd0, m_run});
      check("model_step_pulse", {31'd0, sp}, {31'd0, m_sp});
      check("model_done", {31'd0, done}, {31'd0, m_done});
   endtask

   task automatic cyc();
      @(posedge clk);
      #1;
      model_step();
      cmp_model();
   endtask

   typedef struct {
      logic dir;
      int   per;
      int   steps;
      int   exp_phase;
      int   exp_cycles;
   } scn_t;

   scn_t       scn [5];
   logic [2:0] seq2 [6] = '{3'b110, 3'b010, 3'b011, 3'b001, 3'b101, 3'b100};
   logic [2:0] seq3 [2] = '{3'b101, 3'b001};

   initial begin
      int n, pulses;
      bit seen;
      logic [2:0] ph_before;

      scn[0] = '{1'b1, 4, 6, 0, 24};
      scn[1] = '{1'b0, 3, 2, 4, 6};
      scn[2] = '{1'b1, 0, 5, 3, 5};
      scn[3] = '{1'b0, 2, 7, 2, 14};
      scn[4] = '{1'b1, 1, 1, 3, 1};

      rst_n = 1'b0; start = 0; stop = 0; dir = 1; fault = 0; period = 0; steps = 0;
      model_reset();
      repeat (3) @(posedge clk);
      #1;
      check("reset_hall", {29'd0, ha, hb, hc}, 32'b100);
      check("reset_phase", {29'd0, phase}, 0);
      check("reset_busy", {31'd0, busy}, 0);
      check("reset_done", {31'd0, done}, 0);
      check("reset_step_pulse", {31'd0, sp}, 0);
      rst_n = 1'b1;
      cyc();

      // Finite-mode scenarios
      for (int i = 0; i < 5; i++) begin
         start = 1; dir = scn[i].dir; period = 16'(scn[i].per); steps = 16'(scn[i].steps);
         cyc();
         start = 0;
         check("scn_busy_rise", {31'd0, busy}, 1);
         n = 0; pulses = 0; seen = 0;
         while (n < 200 && !seen) begin
            cyc();
            n++;
            if (sp) begin
               pulses++;
               if (i == 0 && pulses <= 6) check("t2_hall_seq", {29'd0, ha, hb, hc}, {29'd0, seq2[pulses-1]});
               if (i == 1 && pulses <= 2) check("t3_hall_seq", {29'd0, ha, hb, hc}, {29'd0, seq3[pulses-1]});
            end
            if (done) seen = 1;
         end
         check("scn_done_seen", {31'd0, seen}, 1);
         check("scn_done_cycles", n, scn[i].exp_cycles);
         check("scn_pulses", pulses, scn[i].steps);
         check("scn_final_phase", {29'd0, phase}, scn[i].exp_phase);
         check("scn_busy_fall", {31'd0, busy}, 0);
         cyc();
      end

      // Continuous, period 0 -> step every cycle; stop after 10 steps
      start = 1; dir = 1; period = 0; steps = 0;
      cyc();
      start = 0;
      pulses = 0; n = 0;
      while (pulses < 10 && n < 100) begin
         cyc();
         n++;
         if (sp) pulses++;
      end
      check("cont_ten_pulses", n, 10);
      stop = 1;
      cyc();
      stop = 0;
      check("stop_busy", {31'd0, busy}, 0);
      check("stop_phase_hold", {29'd0, phase}, 1);
      check("stop_hall_hold", {29'd0, ha, hb, hc}, 32'b110);
      check("stop_no_done", {31'd0, done}, 0);
      check("stop_no_pulse", {31'd0, sp}, 0);
      repeat (3) cyc();

      // start and stop together in IDLE
      start = 1; stop = 1; period = 5; steps = 3;
      cyc();
      start = 0; stop = 0;
      check("start_stop_idle", {31'd0, busy}, 0);
      cyc();
      // start again during RUN must not restart the counter
      start = 1;
      cyc();
      start = 0;
      cyc(); cyc();
      start = 1;
      cyc();
      start = 0;
      n = 3;
      while (!sp && n < 50) begin
         cyc();
         n++;
      end
      check("restart_ignored", n, 5);
      while (busy && n < 100) begin
         cyc();
         n++;
      end
      check("restart_final_phase", {29'd0, phase}, 4);

      // fault injection mid-run
      start = 1; dir = 0; period = 2; steps = 0;
      cyc();
      start = 0;
      repeat (3) cyc();
      ph_before = phase;
      fault = 1;
      repeat (5) cyc();
      check("fault_hall_zero", {29'd0, ha, hb, hc}, 0);
      check("fault_phase_moves", {31'd0, (phase != ph_before)}, 1);
      fault = 0;
      repeat (3) cyc();
      #2;
      rst_n = 0;
      #1;
      check("async_reset_hall", {29'd0, ha, hb, hc}, 32'b100);
      check("async_reset_busy", {31'd0, busy}, 0);
      check("async_reset_phase", {29'd0, phase}, 0);
      model_reset();
      @(negedge clk);
      rst_n = 1;
      cyc();

      // randomized stimulus against the model
      for (int k = 0; k < 2000; k++) begin
         start  = ($urandom_range(0, 9) == 0);
         stop   = ($urandom_range(0, 39) == 0);
         dir    = 1'($urandom_range(0, 1));
         period = 16'($urandom_range(0, 4));
         steps  = 16'($urandom_range(0, 5));
         fault  = ($urandom_range(0, 29) == 0);
         cyc();
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
